fetch_pc_gen: RTL
=================

// Module: fetch_pc_gen
// PURPOSE
//  Fetch-stage next-PC generator for the 2-way superscalar front end; consumer of the BTB read port.
//  Holds the fetch PC, drives the icache, and looks up the BTB with the slot-0 PC.
//  Predicts direction with a bimodal 2-bit counter table and emits a registered 2-slot fetch packet.
//  Accepts redirects from branch resolution and stalls from the instruction buffer.
// PARAMETERS
//  RESET_PC     32'h0000_0000  fetch PC after reset
//  PHT_ENTRIES  64             bimodal counters, power of 2
//  PHT_IDX_W    $clog2(PHT_ENTRIES)  PHT index width, index = PC[PHT_IDX_W+1:2]
// PORTS
//  clock          in   1   single clock, all state on posedge
//  reset          in   1   asynchronous, active-high
//  proc2Icache_addr out 32  {PC[31:3],3'b0}, 8-byte block address
//  Icache_data    in   64  instruction block; [31:0]=PC[2]==0 word, [63:32]=PC[2]==1 word
//  Icache_valid   in   1   Icache_data valid this cycle (0 = miss)
//  btb_read_en    out  1   BTB lookup enable, high in FETCH state
//  btb_branchPC   out  32  current slot-0 fetch PC
//  btb_targetPC   in   32  BTB target, same-cycle combinational
//  btb_hit        in   1   BTB hit, same-cycle combinational
//  if_stall       in   1   instruction buffer cannot accept a packet
//  redirect_en    in   1   mispredict/exception redirect
//  redirect_pc    in   32  new fetch PC, word aligned
//  br_update_en   in   1   resolved conditional branch: train PHT
//  br_update_pc   in   32  PC of resolved branch
//  br_taken       in   1   resolved direction
//  if_valid       out  2   per-slot packet valid
//  if_pc0/if_pc1  out  32  slot PCs
//  if_inst0/if_inst1 out 32  slot instructions
//  if_pred_taken  out  1   slot-0 predicted taken
//  if_pred_target out  32  predicted next PC of the packet
// BEHAVIOUR
//  Reset: PC=RESET_PC, state=FETCH, if_valid=0, all other packet outputs 0, all PHT counters 2'b01.
//  Slots: slot0=PC; slot1=PC+4, valid only if PC[2]==0 (no crossing of 8-byte block).
//  Prediction: taken = btb_hit & pht[idx(PC)][1]. Only slot 0 is predicted.
//   taken  -> next PC = btb_targetPC; slot 1 suppressed.
//   !taken -> next PC = PC[2] ? PC+4 : PC+8.
//   btb_hit with counter[1]==0 -> fall through; if_pred_target = fall-through PC.
//  FSM states FETCH, MISS, HOLD:
//   FETCH: Icache_valid & !if_stall -> load packet, PC<=next, stay in FETCH.
//          !Icache_valid -> MISS. Icache_valid & if_stall -> HOLD, PC kept.
//   MISS: btb_read_en=0; icache address held; Icache_valid -> FETCH next cycle (re-lookup BTB).
//   HOLD: packet registers frozen (if_valid held); !if_stall -> FETCH. PC does not advance.
//  Packet latency: 1 cycle from accepted icache hit to if_valid. Packet regs update only on accept;
//   when FETCH has no accept and no hold, if_valid<=0 next cycle.
//  Redirect (highest priority, any state): PC<=redirect_pc, state<=FETCH, if_valid<=0;
//   same-cycle icache data and BTB result discarded; overrides if_stall.
//  PHT update: on br_update_en, counter at idx(br_update_pc) saturating +1 if br_taken else -1;
//   11 stays 11, 00 stays 00. Update and lookup of same index in one cycle: lookup sees old value.
//  Update is independent of stall/redirect; simultaneous redirect+update both take effect.
//  PC arithmetic is 32-bit mod 2^32; PC+8 at 32'hFFFF_FFF8 wraps to 0.
//  Reset mid-operation: async clear to reset values regardless of state; pending miss dropped.
// STRUCTURE
//  Shared package: fetch_state_e {FETCH,MISS,HOLD}, IF_PACKET struct (valid, pc, inst, pred fields),
//   PHT counter typedef and PHT_INIT=2'b01.
//  One sub-module: bimodal_pht (PHT_ENTRIES x 2-bit, async-read, sync saturating update).
// TESTING
//  Cold fetch: reset, RESET_PC=0, Icache_valid=1, btb_hit=0 -> next cycle if_valid=2'b11, if_pc0=0, if_pc1=4; next PC 8.
//  Odd PC: redirect_pc=32'h0000_002C -> packet if_valid=2'b01, if_pc0=2C; next PC 30.
//  BTB hit gated: btb_hit=1, target=32'h1122_1320, counter 01 -> fall-through; two br_update taken
//   (01->10->11) -> then PC lands on 1122_1320, slot1 suppressed, if_pred_taken=1.
//  Saturation: 4 not-taken updates from 11 -> 00, fifth stays 00; same-cycle lookup sees pre-update value.
//  Miss + stall: Icache_valid=0 3 cycles -> if_valid=0, addr held; then if_stall=1 -> HOLD, packet frozen.
//  Redirect priority: redirect_en with if_stall=1 and Icache_valid=1 -> if_valid=0 next cycle,
//   PC=redirect_pc; async reset asserted mid-MISS -> outputs cleared immediately.

Source files
------------

// File: rtl/fetch_pc_gen_pkg.sv
// fetch_pc_gen_pkg: shared types for the fetch next-PC generator
package fetch_pc_gen_pkg;
  typedef enum logic [1:0] {FETCH, MISS, HOLD} fetch_state_e;
  typedef logic [1:0] pht_ctr_t;
  localparam pht_ctr_t PHT_INIT = 2'b01;
  typedef struct packed {
    logic [1:0]  valid;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic        pred_taken;
    logic [31:0] pred_target;
  } if_packet_t;
  function automatic pht_ctr_t sat_step(input pht_ctr_t c, input logic taken);
    return taken ? ((c == 2'b11) ? c : c + 2'd1) : ((c == 2'b00) ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: icache, BTB, redirect, training and fetch-packet signals
interface fetch_pc_gen_if;
  logic [31:0] proc2Icache_addr;
  logic [63:0] Icache_data;
  logic        Icache_valid;
  logic        btb_read_en;
  logic [31:0] btb_branchPC;
  logic [31:0] btb_targetPC;
  logic        btb_hit;
  logic        if_stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        br_update_en;
  logic [31:0] br_update_pc;
  logic        br_taken;
  logic [1:0]  if_valid;
  logic [31:0] if_pc0;
  logic [31:0] if_pc1;
  logic [31:0] if_inst0;
  logic [31:0] if_inst1;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  modport master (
    output proc2Icache_addr, btb_read_en, btb_branchPC, if_valid, if_pc0, if_pc1,
           if_inst0, if_inst1, if_pred_taken, if_pred_target,
    input  Icache_data, Icache_valid, btb_targetPC, btb_hit, if_stall, redirect_en,
           redirect_pc, br_update_en, br_update_pc, br_taken
  );
  modport slave (
    input  proc2Icache_addr, btb_read_en, btb_branchPC, if_valid, if_pc0, if_pc1,
           if_inst0, if_inst1, if_pred_taken, if_pred_target,
    output Icache_data, Icache_valid, btb_targetPC, btb_hit, if_stall, redirect_en,
           redirect_pc, br_update_en, br_update_pc, br_taken
  );
endinterface

// File: rtl/fetch_pc_gen_pht.sv
// bimodal_pht: 2-bit saturating counter table, async read, sync update
module bimodal_pht
  import fetch_pc_gen_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output pht_ctr_t         rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);
  pht_ctr_t pht [ENTRIES];
  assign rd_ctr = pht[rd_idx];
  always_ff @(posedge clock or posedge reset)
    if (reset)
      for (int i = 0; i < ENTRIES; i++) pht[i] <= PHT_INIT;
    else if (upd_en)
      pht[upd_idx] <= sat_step(pht[upd_idx], upd_taken);
endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC register, bimodal+BTB prediction and 2-slot fetch packet
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          PHT_ENTRIES = 64,
  parameter int          PHT_IDX_W   = $clog2(PHT_ENTRIES)
) (
  input logic           clock,
  input logic           reset,
  fetch_pc_gen_if.master bus
);
  fetch_state_e state;
  logic [31:0]  pc, fall, pred_next;
  pht_ctr_t     ctr;
  logic         taken;
  if_packet_t   pkt, pkt_new;
  bimodal_pht #(.ENTRIES(PHT_ENTRIES), .IDX_W(PHT_IDX_W)) u_pht (
    .clock    (clock),
    .reset    (reset),
    .rd_idx   (pc[PHT_IDX_W+1:2]),
    .rd_ctr   (ctr),
    .upd_en   (bus.br_update_en),
    .upd_idx  (bus.br_update_pc[PHT_IDX_W+1:2]),
    .upd_taken(bus.br_taken)
  );
  // A predicted-taken slot 0 ends the packet, so slot 1 is dropped
  always_comb begin
    taken               = bus.btb_hit & ctr[1];
    fall                = pc[2] ? pc + 32'd4 : pc + 32'd8;
    pred_next           = taken ? bus.btb_targetPC : fall;
    pkt_new.valid       = taken ? 2'b01 : {~pc[2], 1'b1};
    pkt_new.pc0         = pc;
    pkt_new.pc1         = pc + 32'd4;
    pkt_new.inst0       = pc[2] ? bus.Icache_data[63:32] : bus.Icache_data[31:0];
    pkt_new.inst1       = bus.Icache_data[63:32];
    pkt_new.pred_taken  = taken;
    pkt_new.pred_target = pred_next;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pc    <= RESET_PC;
      state <= FETCH;
      pkt   <= '0;
    end else if (bus.redirect_en) begin
      pc        <= bus.redirect_pc;
      state     <= FETCH;
      pkt.valid <= 2'b00;
    end else
      case (state)
        FETCH:
          if (!bus.Icache_valid) begin
            state     <= MISS;
            pkt.valid <= 2'b00;
          end else if (bus.if_stall)
            state <= HOLD;
          else begin
            pkt <= pkt_new;
            pc  <= pred_next;
          end
        MISS: begin
          pkt.valid <= 2'b00;
          if (bus.Icache_valid) state <= FETCH;
        end
        HOLD: if (!bus.if_stall) state <= FETCH;
        default: state <= FETCH;
      endcase
  assign bus.proc2Icache_addr = {pc[31:3], 3'b000};
  assign bus.btb_read_en      = state == FETCH;
  assign bus.btb_branchPC     = pc;
  assign bus.if_valid         = pkt.valid;
  assign bus.if_pc0           = pkt.pc0;
  assign bus.if_pc1           = pkt.pc1;
  assign bus.if_inst0         = pkt.inst0;
  assign bus.if_inst1         = pkt.inst1;
  assign bus.if_pred_taken    = pkt.pred_taken;
  assign bus.if_pred_target   = pkt.pred_target;
endmodule
